// File: rtl/mode_output_collector_if.sv
// ----------------------------------------------------------------------------
// mode_output_collector_if : producer/consumer bundle for the collector FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mode_output_collector_if #(
  parameter int n     = 8,
  parameter int DEPTH = 8
);
  logic [2:0]               select;
  logic [n-1:0]             data1;
  logic [n-1:0]             data2;
  logic                     in_valid;
  logic                     in_ready;
  logic [n-1:0]             out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     mode_err;

  modport master (
    output select, data1, data2, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, mode_err
  );

  modport slave (
    input  select, data1, data2, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, mode_err
  );
endinterface

`default_nettype wire

// File: rtl/mode_output_collector.sv
// ----------------------------------------------------------------------------
// mode_output_collector : mode-decoded 0/1/2-byte writer into a byte FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mode_output_collector #(
  parameter int n     = 8,
  parameter int DEPTH = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mode_output_collector_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_ready_max = CW'(DEPTH - 2);
  localparam logic [AW-1:0] c_one       = AW'(1);

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_mode_err;

  logic [1:0]    w_nbytes;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_inc;
  logic [CW-1:0] w_dec;

  always_comb begin
    w_nbytes = 2'd0;
    case (bus.select)
      3'b000, 3'b001, 3'b100, 3'b101: w_nbytes = 2'd1;
      3'b010, 3'b011:                 w_nbytes = 2'd2;
      default:                        w_nbytes = 2'd0;
    endcase
  end

  // Two free slots are required so a 2-byte push can never overflow.
  assign bus.in_ready  = (r_count <= c_ready_max);
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = (r_count != '0) ? mem[r_rd_ptr] : '0;
  assign bus.count     = r_count;
  assign bus.mode_err  = r_mode_err;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;
  assign w_inc  = w_push ? CW'(w_nbytes) : '0;
  assign w_dec  = CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push && (w_nbytes != 2'd0)) begin
      mem[r_wr_ptr] <= bus.data1;
    end
    if (w_push && (w_nbytes == 2'd2)) begin
      mem[r_wr_ptr + c_one] <= bus.data2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mode_err <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_inc);
      r_rd_ptr   <= r_rd_ptr + AW'(w_dec);
      r_count    <= r_count + w_inc - w_dec;
      r_mode_err <= w_push && (w_nbytes == 2'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mode_output_collector.sv
// ----------------------------------------------------------------------------
// tb_mode_output_collector : directed + random bench against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mode_output_collector;

  localparam int N     = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mode_output_collector_if #(.n(N), .DEPTH(DEPTH)) bus ();

  mode_output_collector #(.n(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] q[$];
  logic       exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"},     32'(bus.count),     32'(q.size()));
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    check({tag, "_out_data"},  32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'(q.size() <= DEPTH - 2));
    check({tag, "_mode_err"},  32'(bus.mode_err),  32'(exp_err));
  endtask

  // Model: occupancy is the queue length; the head is q[0].
  task automatic model_edge(input logic v, input logic [2:0] s,
                            input logic [7:0] d1, input logic [7:0] d2, input logic ordy);
    bit acc;
    bit pop;
    acc = v && (q.size() <= DEPTH - 2);
    pop = ordy && (q.size() != 0);
    if (pop) void'(q.pop_front());
    exp_err = 1'b0;
    if (acc) begin
      if (s == 3'd6 || s == 3'd7) exp_err = 1'b1;
      else begin
        q.push_back(d1);
        if (s == 3'd2 || s == 3'd3) q.push_back(d2);
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] s,
                      input logic [7:0] d1, input logic [7:0] d2, input logic ordy);
    bus.in_valid  = v;
    bus.select    = s;
    bus.data1     = d1;
    bus.data2     = d2;
    bus.out_ready = ordy;
    @(posedge clk);
    model_edge(v, s, d1, d2, ordy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 3'd0, 8'h00, 8'h00, ordy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.select    = 3'd0;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Scenario 1: one 2-byte push, drained on consecutive cycles
    step("s1_push", 1'b1, 3'b010, 8'h00, 8'h01, 1'b1);
    check("s1_count2", 32'(bus.count), 32'd2);
    idle("s1_pop1", 1'b1);
    check("s1_head01", 32'(bus.out_data), 32'h01);
    idle("s1_pop2", 1'b1);

    // Scenario 2: fill to DEPTH with 2-byte pushes, fifth is refused
    for (int i = 0; i < 4; i++)
      step("s2_fill", 1'b1, 3'b011, 8'($urandom), 8'($urandom), 1'b0);
    check("s2_full_in_ready", 32'(bus.in_ready), 32'd0);
    step("s2_refused", 1'b1, 3'b011, 8'hAA, 8'hBB, 1'b0);
    check("s2_count8", 32'(bus.count), 32'd8);
    for (int i = 0; i < DEPTH; i++) idle("s2_drain", 1'b1);

    // Scenario 3: 20 single bytes streamed through while popping
    for (int i = 0; i < 20; i++)
      step("s3_stream", 1'b1, 3'b000, 8'(i + 8'h40), 8'hFF, 1'b1);
    idle("s3_drain", 1'b1);

    // Scenario 4: invalid mode at count 3
    step("s4_a", 1'b1, 3'b010, 8'h11, 8'h12, 1'b0);
    step("s4_b", 1'b1, 3'b100, 8'h13, 8'hEE, 1'b0);
    step("s4_inv", 1'b1, 3'b110, 8'h99, 8'h98, 1'b0);
    check("s4_err_hi", 32'(bus.mode_err), 32'd1);
    idle("s4_err_lo", 1'b0);

    // Scenario 5: 2-byte push with simultaneous pop at count 3
    step("s5_pushpop", 1'b1, 3'b010, 8'h21, 8'h22, 1'b1);
    check("s5_count4", 32'(bus.count), 32'd4);

    // Scenario 6: asynchronous reset at count 5
    step("s6_fill", 1'b1, 3'b001, 8'h31, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    exp_err = 1'b0;
    check_all("s6_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle("s6_after", 1'b1);
    idle("s6_after2", 1'b1);

    // Randomised traffic, including back-to-back invalid modes
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 4; i++)
      step("rand_inv", 1'b1, 3'b111, 8'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) idle("final_drain", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mode_output_collector.md
MODE_OUTPUT_COLLECTOR -- requirements
Module: mode_output_collector

Interface
REQ-001 The module SHALL have parameter n, default 8: byte-lane width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 8: FIFO depth in entries, a power of two and at least 4.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port select, input, 3 bits: mode code qualifying data1/data2.
REQ-006 The module SHALL have port data1, input, n bits: first lane from the mode input selector.
REQ-007 The module SHALL have port data2, input, n bits: second lane from the mode input selector.
REQ-008 The module SHALL have port in_valid, input, 1 bit: producer presents select/data1/data2.
REQ-009 The module SHALL have port in_ready, output, 1 bit: collector can accept a transfer.
REQ-010 The module SHALL have port out_data, output, n bits: head-of-FIFO byte.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-012 The module SHALL have port out_ready, input, 1 bit: consumer takes out_data.
REQ-013 The module SHALL have port count, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 The module SHALL have port mode_err, output, 1 bit: one-cycle pulse after an invalid-mode transfer.

Function
REQ-015 Push SHALL occur on a rising edge where in_valid and in_ready are both 1; pop SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-016 The select decode SHALL be as follows:
- 000, 001, 100, 101: write 1 byte (data1).
- 010, 011: write 2 bytes (data1, then data2).
- 110, 111: write 0 bytes (invalid).
REQ-017 In a 2-byte push, data1 SHALL be written at wr_ptr and data2 at wr_ptr+1 modulo DEPTH; wr_ptr SHALL advance by the number of bytes written.
REQ-018 data2 SHALL be ignored in 1-byte modes, and both lanes SHALL be ignored in invalid modes.
REQ-019 in_ready SHALL be a combinational function of registered count only: 1 when count <= DEPTH-2, else 0 (no dependence on a same-cycle pop).
REQ-020 out_valid SHALL be 1 when count != 0; out_data SHALL equal mem[rd_ptr] when count != 0 and all-zero when count == 0.
REQ-021 A pop SHALL advance rd_ptr by 1 modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL be legal, with next count = count + bytes_written - 1 (pop only when count != 0).
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or reordering; output order SHALL equal write order (data1 before data2).
REQ-024 Latency SHALL be one cycle: a byte pushed at edge k SHALL be visible on out_data after edge k when it is the head entry.
REQ-025 count SHALL never exceed DEPTH and SHALL never underflow; a pop with count == 0 SHALL be impossible by construction.
REQ-026 An accepted invalid-mode transfer SHALL leave count and pointers unchanged and SHALL set mode_err to 1 for exactly the following cycle; back-to-back invalid transfers SHALL keep mode_err high each cycle.
REQ-027 A non-accepted transfer (in_ready == 0) SHALL have no effect, including on mode_err.

Reset
REQ-028 On rst_n == 0 the module SHALL immediately set wr_ptr = 0, rd_ptr = 0, count = 0, mode_err = 0, out_valid = 0, out_data = 0 and in_ready = 1, independent of clk.
REQ-029 Assertion of rst_n mid-operation SHALL discard all stored bytes; memory contents SHALL need no reset.
REQ-030 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 Scenario 1: after reset, one push with select=010, data1=0x00, data2=0x01, with out_ready=1 -> out_data shows 0x00 then 0x01 on consecutive cycles; count goes 2 -> 1 -> 0.
REQ-032 Scenario 2: with out_ready=0, push select=011 four times (DEPTH=8) -> count goes 2, 4, 6, 8; in_ready = 0 at count 8; a fifth in_valid is not accepted and count stays 8.
REQ-033 Scenario 3 (wrap-around): repeatedly push select=000 with incrementing data1 while popping, over 20 bytes -> output sequence identical to input; pointers wrap at least twice.
REQ-034 Scenario 4: at count=3, push select=110 -> count stays 3, mode_err = 1 for one cycle, then 0.
REQ-035 Scenario 5: at count=3, push 2 bytes (select=010) with a simultaneous pop -> count = 4 and the head byte advances.
REQ-036 Scenario 6: at count=5, pull rst_n low between clock edges -> count = 0, out_valid = 0, out_data = 0 and in_ready = 1 without waiting for clk; no old byte appears after release.
